// File: rtl/spi_pkg.sv
// spi_pkg: frame constants and controller state encoding shared by the SPI
// initiator (spi_master_ctrl) and the SPI peripheral that decodes its frames.
//
// A frame is ADDR (MSB first), one R/W bit, then DATA (MSB first).
package spi_pkg;

  localparam int SPI_ADDR_W  = 7;
  localparam int SPI_DATA_W  = 8;
  localparam int SPI_FRAME_W = 16;

  localparam logic SPI_RW_READ  = 1'b1;
  localparam logic SPI_RW_WRITE = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } spi_state_e;

endpackage

// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen: half-period divider and serial-clock register for the SPI
// initiator.
//
// Ports:
//   i_clk, i_rst_n  system clock, asynchronous active-low reset
//   i_en            divider runs while high; held at zero otherwise
//   i_clear         restart the half-period count (FSM state change)
//   i_toggle        sclk may toggle; sclk is forced low while this is low
//   o_tick          last cycle of a half-period (acts on the coming edge)
//   o_pre_tick      one cycle before o_tick would fire
//   o_rise/o_fall   sclk rises / falls on the coming clk edge
//   o_sclk          registered serial clock, idle low
module spi_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_clear,
  input  logic i_toggle,
  output logic o_tick,
  output logic o_pre_tick,
  output logic o_rise,
  output logic o_fall,
  output logic o_sclk
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLK_DIV - 2);

  logic [CNT_W-1:0] r_cnt;
  logic             r_sclk;

  assign o_tick     = i_en && (r_cnt == CNT_LAST);
  assign o_pre_tick = i_en && (r_cnt == CNT_PRE);
  assign o_rise     = o_tick && i_toggle && !r_sclk;
  assign o_fall     = o_tick && i_toggle && r_sclk;
  assign o_sclk     = r_sclk;

  // The count never passes CNT_LAST: it returns to zero on every tick.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (!i_en || i_clear || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sclk <= 1'b0;
    end else if (!i_toggle) begin
      r_sclk <= 1'b0;
    end else if (o_tick) begin
      r_sclk <= !r_sclk;
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: SPI mode-0 initiator. Each accepted request produces one
// frame {addr, rw, data}, all MSB first, with cs low around 16 sclk pulses.
// Read frames send zeros in the data field and return the captured miso
// byte on rdata.
//
// Ports:
//   clk, reset_n         system clock, asynchronous active-low reset
//   start, rw, addr,     request; sampled together when the controller is
//   wdata                idle (busy low as seen by that edge)
//   busy                 request in progress
//   done                 one-cycle pulse when cs returns high
//   rdata                last read byte, valid from done onward
//   cs, sclk, mosi       SPI pins (registered)
//   miso                 SPI data from the peripheral
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int ADDR_W  = SPI_ADDR_W,
  parameter int DATA_W  = SPI_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              cs,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso
);

  localparam int FRAME_W = ADDR_W + 1 + DATA_W;
  localparam int BIT_W   = $clog2(FRAME_W) + 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_W - 1);
  localparam logic [BIT_W-1:0] FIRST_RX = BIT_W'(ADDR_W + 1);

  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("spi_master_ctrl: CLK_DIV must be 2 or more");
  end

  spi_state_e r_state, w_state;

  // The frame MSB goes straight to mosi at acceptance, so the shift
  // register only holds the bits still to be sent.
  logic [FRAME_W-2:0] r_tx,  w_tx;
  logic [DATA_W-1:0]  r_rx,  w_rx;
  logic [DATA_W-1:0]  r_rdata, w_rdata;
  logic [BIT_W-1:0]   r_bit, w_bit;
  logic               r_rw,  w_rw;
  logic               r_busy, w_busy;
  logic               r_done, w_done;
  logic               r_cs,  w_cs;
  logic               r_mosi, w_mosi;

  logic w_en, w_clear, w_toggle;
  logic w_tick, w_pre_tick, w_rise, w_fall, w_sclk;

  assign w_en     = (r_state != ST_IDLE);
  assign w_toggle = (r_state == ST_SETUP) || (r_state == ST_SHIFT);
  assign w_clear  = (w_state != r_state);

  spi_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .i_clk      (clk),
    .i_rst_n    (reset_n),
    .i_en       (w_en),
    .i_clear    (w_clear),
    .i_toggle   (w_toggle),
    .o_tick     (w_tick),
    .o_pre_tick (w_pre_tick),
    .o_rise     (w_rise),
    .o_fall     (w_fall),
    .o_sclk     (w_sclk)
  );

  always_comb begin
    w_state = r_state;
    w_tx    = r_tx;
    w_rx    = r_rx;
    w_rdata = r_rdata;
    w_bit   = r_bit;
    w_rw    = r_rw;
    w_busy  = r_busy;
    w_done  = 1'b0;
    w_cs    = r_cs;
    w_mosi  = r_mosi;

    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_tx    = {addr[ADDR_W-2:0], rw,
                     (rw == SPI_RW_READ) ? {DATA_W{1'b0}} : wdata};
          w_rw    = rw;
          w_busy  = 1'b1;
          w_cs    = 1'b0;
          w_mosi  = addr[ADDR_W-1];
          w_bit   = '0;
          w_state = ST_SETUP;
        end
      end

      // First sclk rise (bit 0) happens on the tick that leaves SETUP.
      ST_SETUP: begin
        if (w_tick) begin
          w_state = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (w_rise && (r_bit >= FIRST_RX)) begin
          w_rx = {r_rx[DATA_W-2:0], miso};
        end
        if (w_fall) begin
          if (r_bit == LAST_BIT) begin
            // Last bit stays on mosi through HOLD.
            w_bit   = '0;
            w_state = ST_HOLD;
          end else begin
            w_bit  = r_bit + 1'b1;
            w_mosi = r_tx[FRAME_W-2];
            w_tx   = {r_tx[FRAME_W-3:0], 1'b0};
          end
        end
      end

      ST_HOLD: begin
        if (w_tick) begin
          w_cs    = 1'b1;
          w_mosi  = 1'b0;
          w_done  = 1'b1;
          if (r_rw == SPI_RW_READ) begin
            w_rdata = r_rx;
          end
          w_state = ST_GAP;
        end
      end

      // Leave one cycle early so busy is already low on the edge that
      // completes the H-cycle gap; a waiting start is taken on that edge,
      // giving exactly H cycles of cs high between frames.
      ST_GAP: begin
        if (w_pre_tick) begin
          w_busy  = 1'b0;
          w_state = ST_IDLE;
        end
      end

      default: begin
        w_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx    <= '0;
      r_rx    <= '0;
      r_rdata <= '0;
      r_bit   <= '0;
      r_rw    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cs    <= 1'b1;
      r_mosi  <= 1'b0;
    end else begin
      r_tx    <= w_tx;
      r_rx    <= w_rx;
      r_rdata <= w_rdata;
      r_bit   <= w_bit;
      r_rw    <= w_rw;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_cs    <= w_cs;
      r_mosi  <= w_mosi;
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign rdata = r_rdata;
  assign cs    = r_cs;
  assign sclk  = w_sclk;
  assign mosi  = r_mosi;

endmodule
